// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the sequential magnitude comparator (cmp_seq) and its
// digit-compare slice (cmp_digit).
//   - state_e   : FSM state encoding (IDLE/RUN/DONE). The spare code 2'b11 is
//                 never entered and is handled as IDLE by the FSM.
//   - DEF_*     : default operand and digit widths.
//   - cnt_width : width of the digit counter for a given digit count
//                 (clog2, never below one bit).
// -----------------------------------------------------------------------------
package cmp_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Number of digits in an operand.
  function automatic int ndig_of(input int width, input int digit_w);
    return width / digit_w;
  endfunction

  // Counter width: enough to index every digit, at least one bit.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// -----------------------------------------------------------------------------
// cmp_digit
// Purely combinational unsigned compare of one DIGIT_W-bit digit.
// Ports:
//   dig_a, dig_b : input  [DIGIT_W-1:0] digits to compare (unsigned)
//   lt           : output 1 when dig_a <  dig_b
//   eq           : output 1 when dig_a == dig_b
// -----------------------------------------------------------------------------
module cmp_digit
  import cmp_pkg::*;
#(
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic [DIGIT_W-1:0] dig_a,
  input  logic [DIGIT_W-1:0] dig_b,
  output logic               lt,
  output logic               eq
);

  assign lt = (dig_a < dig_b);
  assign eq = (dig_a == dig_b);

endmodule

// File: rtl/cmp_seq.sv
// -----------------------------------------------------------------------------
// cmp_seq
// Sequential magnitude comparator. Compares two WIDTH-bit operands MSB-first,
// DIGIT_W bits per cycle, stopping at the first differing digit, and produces
// the less/equal pair consumed by comp_dcd.
// Ports:
//   clk      : input  clock, rising edge
//   reset    : input  asynchronous active-high reset
//   start    : input  request, sampled in IDLE or DONE only
//   sgn      : input  1 = two's-complement compare, 0 = unsigned
//   a, b     : input  [WIDTH-1:0] operands, sampled with start
//   busy     : output high while comparing (RUN)
//   done     : output one-cycle completion pulse (DONE)
//   less_out : output A < B, held until the next completion
//   eql_out  : output A == B, held until the next completion
// WIDTH must be a multiple of DIGIT_W.
// -----------------------------------------------------------------------------
module cmp_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             less_out,
  output logic             eql_out
);

  localparam int NDIG  = ndig_of(WIDTH, DIGIT_W);
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             less_q, less_d;
  logic             eql_q, eql_d;

  logic             dig_lt;
  logic             dig_eq;

  // Only the top digit of each shift register is ever examined.
  cmp_digit #(
    .DIGIT_W (DIGIT_W)
  ) u_digit (
    .dig_a (a_q[WIDTH-1 -: DIGIT_W]),
    .dig_b (b_q[WIDTH-1 -: DIGIT_W]),
    .lt    (dig_lt),
    .eq    (dig_eq)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    less_d  = less_q;
    eql_d   = eql_q;

    case (state_q)
      ST_RUN: begin
        if (!dig_eq) begin
          less_d  = dig_lt;
          eql_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == LAST_DIG) begin
          less_d  = 1'b0;
          eql_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          a_d   = a_q << DIGIT_W;
          b_d   = b_q << DIGIT_W;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // IDLE, DONE and the unused code all accept a new request.
      default: begin
        if (start) begin
          // Flipping the sign bit of both operands maps two's-complement
          // order onto plain unsigned order, so RUN needs no signed logic.
          a_d     = {a[WIDTH-1] ^ sgn, a[WIDTH-2:0]};
          b_d     = {b[WIDTH-1] ^ sgn, b[WIDTH-2:0]};
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      less_q  <= 1'b0;
      eql_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      less_q  <= less_d;
      eql_q   <= eql_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign less_out = less_q;
  assign eql_out  = eql_q;

endmodule

// File: tb/tb_cmp_seq.sv
// -----------------------------------------------------------------------------
// tb_cmp_seq
// Self-checking bench for cmp_seq: a reference model derived from plain signed/
// unsigned arithmetic is compared against the DUT on every falling edge, and
// directed scenarios check hand-computed latencies and results.
// -----------------------------------------------------------------------------
module tb_cmp_seq;

  localparam int WIDTH   = 32;
  localparam int DIGIT_W = 4;
  localparam int NDIG    = WIDTH / DIGIT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             sgn = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, less_out, eql_out;

  int n_cmp = 0;
  int n_bad = 0;

  cmp_seq #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sgn      (sgn),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .less_out (less_out),
    .eql_out  (eql_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Number of RUN cycles: index of first differing 4-bit digit + 1, or NDIG.
  function automatic int run_cycles(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    for (int i = 0; i < NDIG; i++) begin
      if (x[WIDTH-1-DIGIT_W*i -: DIGIT_W] != y[WIDTH-1-DIGIT_W*i -: DIGIT_W])
        return i + 1;
    end
    return NDIG;
  endfunction

  int   m_phase = 0;  // 0 idle, 1 comparing, 2 completion cycle
  int   m_rem   = 0;
  logic m_less  = 1'b0;
  logic m_eql   = 1'b0;
  logic p_less  = 1'b0;
  logic p_eql   = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_rem   <= 0;
      m_less  <= 1'b0;
      m_eql   <= 1'b0;
    end else if (m_phase == 1) begin
      if (m_rem == 1) begin
        m_phase <= 2;
        m_less  <= p_less;
        m_eql   <= p_eql;
      end else begin
        m_rem <= m_rem - 1;
      end
    end else if (start) begin
      m_phase <= 1;
      m_rem   <= run_cycles(a, b);
      p_eql   <= (a == b);
      p_less  <= sgn ? ($signed(a) < $signed(b)) : (a < b);
    end else begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    chk("model_busy", int'(busy), int'(m_phase == 1));
    chk("model_done", int'(done), int'(m_phase == 2));
    chk("model_less", int'(less_out), int'(m_less));
    chk("model_eql",  int'(eql_out),  int'(m_eql));
    if (less_out && eql_out) chk("less_and_eql", 1, 0);
  end

  // ---------------- directed helpers ----------------
  // Called at a falling edge: present a request for the next rising edge.
  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv);
    start = 1'b1;
    a     = av;
    b     = bv;
    sgn   = sv;
  endtask

  // Starting at the falling edge just after the start edge, count RUN cycles
  // until done. start is held for 'hold' further edges, then dropped and the
  // operand inputs scrambled.
  task automatic wait_done(input int hold, output int runs, output int got);
    int edges;
    edges = 0;
    runs  = 0;
    got   = 0;
    if (hold == 0) begin
      start = 1'b0;
      a = $urandom; b = $urandom; sgn = 1'($urandom);
    end
    for (int n = 0; n < 40; n++) begin
      if (done) begin
        got = 1;
        break;
      end
      if (busy) runs++;
      @(negedge clk);
      edges++;
      if (edges >= hold && start) begin
        start = 1'b0;
        a = $urandom; b = $urandom; sgn = 1'($urandom);
      end
    end
    if (!got) $display("FAIL timeout: got no done expected done within 40 cycles");
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic sv, input int hold, input int exp_runs,
                        input logic exp_less, input logic exp_eql);
    int runs, got;
    @(negedge clk);
    launch(av, bv, sv);
    @(negedge clk);
    wait_done(hold, runs, got);
    chk({name, "_done_seen"}, got, 1);
    chk({name, "_runs"}, runs, exp_runs);
    chk({name, "_less"}, int'(less_out), int'(exp_less));
    chk({name, "_eql"},  int'(eql_out),  int'(exp_eql));
    $display("op %s a=%08h b=%08h sgn=%0d runs=%0d less=%0d eql=%0d",
             name, av, bv, sv, runs, less_out, eql_out);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int runs, got;

    #23 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_less", int'(less_out), 0);
    chk("rst_eql",  int'(eql_out), 0);

    run_op("early_u",  32'h8000_0000, 32'h0000_0000, 1'b0, 0, 1, 1'b0, 1'b0);
    run_op("early_s",  32'h8000_0000, 32'h0000_0000, 1'b1, 0, 1, 1'b1, 1'b0);
    run_op("eq_hold",  32'h1234_5678, 32'h1234_5678, 1'b0, 4, 8, 1'b0, 1'b1);
    run_op("last_u",   32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 0, 8, 1'b1, 1'b0);
    run_op("last_s",   32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 0, 8, 1'b1, 1'b0);
    run_op("neg_pos",  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0, 1, 1'b1, 1'b0);
    run_op("mid_u",    32'h1230_0000, 32'h1290_0000, 1'b0, 0, 3, 1'b1, 1'b0);

    // Back-to-back: equal compare, then a request in its DONE cycle.
    run_op("b2b_first", 32'h1234_5678, 32'h1234_5678, 1'b0, 0, 8, 1'b0, 1'b1);
    launch(32'd5, 32'd3, 1'b0);
    @(negedge clk);
    chk("b2b_busy",     int'(busy), 1);
    chk("b2b_old_eql",  int'(eql_out), 1);
    chk("b2b_old_less", int'(less_out), 0);
    wait_done(0, runs, got);
    chk("b2b_done_seen", got, 1);
    chk("b2b_runs", runs, 8);
    chk("b2b_less", int'(less_out), 0);
    chk("b2b_eql",  int'(eql_out), 0);
    $display("op b2b a=5 b=3 runs=%0d less=%0d eql=%0d", runs, less_out, eql_out);

    // Reset in the third RUN cycle of an equal compare.
    run_op("pre_rst", 32'd7, 32'd7, 1'b0, 0, 8, 1'b0, 1'b1);
    @(negedge clk);
    launch(32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_less", int'(less_out), 0);
    chk("mid_rst_eql",  int'(eql_out), 0);
    $display("op mid_reset busy=%0d done=%0d less=%0d eql=%0d", busy, done, less_out, eql_out);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", int'(done), 0);
    end
    run_op("after_rst", 32'd1, 32'd2, 1'b0, 0, 8, 1'b1, 1'b0);

    // A few model-checked random compares, with shared upper digits to
    // exercise varying exit points.
    for (int i = 0; i < 12; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic rs;
      ra = $urandom;
      rb = (ra & ~((32'hFFFF_FFFF) >> (4 * (i % 8)))) | ($urandom >> (4 * (i % 8)));
      rs = 1'(i % 2);
      @(negedge clk);
      launch(ra, rb, rs);
      @(negedge clk);
      wait_done(0, runs, got);
      chk("rand_done_seen", got, 1);
      chk("rand_runs", runs, run_cycles(ra, rb));
      $display("op rand a=%08h b=%08h sgn=%0d runs=%0d less=%0d eql=%0d",
               ra, rb, rs, runs, less_out, eql_out);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmp_seq.md
Name: cmp_seq

Overview:
- Sequential magnitude comparator feeding comp_dcd: takes two 32-bit operands and produces the less_in/eql_in pair that comp_dcd decodes into set-on-compare results.
- Compares MSB-first, DIGIT_W bits per cycle, and stops at the first differing digit.
- Start/done handshake; results are held stable until the next completion, so comp_dcd may sample them at any time after done.

Parameters:
- WIDTH, 32, operand width; must be a multiple of DIGIT_W.
- DIGIT_W, 4, bits compared per cycle; NDIG = WIDTH/DIGIT_W digits (8 by default).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sgn  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse, high in DONE.
- less_out  output  1  A < B; drives comp_dcd less_in.
- eql_out  output  1  A == B; drives comp_dcd eql_in.

Behaviour:
- Clock and reset are fixed: one clock (clk); reset is asynchronous and active-high (reset).
- Reset (async, any state, including mid-RUN):
  - state=IDLE, busy=0, done=0, less_out=0, eql_out=0, digit counter=0.
  - Operand registers go to 0.
  - An in-flight comparison is discarded with no done.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch a and b into shift registers.
  - If sgn=1, invert bit WIDTH-1 of both latched operands. Signed order then equals unsigned order of the modified values.
  - cnt=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - Compare the top DIGIT_W bits of both registers as unsigned: dlt = digA<digB, deq = digA==digB.
  - deq=0: register less_out=dlt, eql_out=0; go to DONE.
  - deq=1 and cnt==NDIG-1: register less_out=0, eql_out=1; go to DONE.
  - Otherwise: shift both registers left by DIGIT_W, cnt=cnt+1, stay in RUN.
  - start is ignored in RUN (no queueing, no restart).
- DONE: done=1 for exactly one cycle.
  - start=1: accepted exactly as from IDLE; next state RUN.
  - start=0: next state IDLE.
- Latency: start sampled at edge E0. If the first differing digit has index k (0 = MSB), done is high in the cycle after edge E0+k+1. That gives 1..NDIG RUN cycles; equal operands take NDIG.
- Back-to-back throughput: one comparison per (RUN cycles + 1).
- Result registers:
  - less_out and eql_out change only at the edge entering DONE.
  - They hold their value through IDLE and through the next RUN.
  - Never less_out=1 and eql_out=1 together.
- a, b and sgn may change freely after the start edge; latched copies are used.
- Counter width is clog2(NDIG), minimum 1. No wrap occurs, because exit at NDIG-1 is forced.

Decomposition:
- Shared package (cmp_pkg):
  - State encoding constants ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10.
  - Default WIDTH and DIGIT_W.
  - Helper for the NDIG and counter widths.
  - The unused code 2'b11 decodes to IDLE.
- One sub-module, cmp_digit: purely combinational DIGIT_W-bit unsigned compare, outputs lt and eq. It is instantiated once on the top digits.
- FSM, counter, shift registers and result registers live in cmp_seq.

Test Plan:
- Early exit, unsigned: a=0x80000000, b=0x00000000, sgn=0. done is high 1 cycle after the start edge; less_out=0, eql_out=0; busy high for 1 cycle.
- Same operands, signed: sgn=1. less_out=1, eql_out=0, same 1-RUN-cycle latency.
- Full-length equality: a=b=0x12345678. busy high 8 cycles, done 8 cycles after start; less_out=0, eql_out=1.
- Last-digit differs: a=0xFFFFFFFE, b=0xFFFFFFFF, unsigned. 8 RUN cycles, less_out=1. With sgn=1 (−2 < −1), also less_out=1.
- Handshake:
  - start held high during RUN has no effect.
  - start in the DONE cycle with a=5, b=3 begins a new RUN immediately; less_out/eql_out keep the old results until the new DONE, then read 0/0.
- Reset mid-operation: assert reset asynchronously in RUN cycle 3 of an equal compare. All outputs drop to 0 immediately with no done pulse. After release, a new start (a=1, b=2) completes normally with less_out=1 after 8 cycles.
